bcd_to_binary_seq: RTL

//  Sequential BCD-to-binary decoder, the inverse of the lab's binary-to-BCD adder/display path.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_digit_corr.sv | 12 +
 rtl/bcd_to_binary_seq.sv | 98 +++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared encodings and digit constants for the sequential BCD-to-binary decoder.
package bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] CORR_THRESH = 4'd8;
  localparam logic [3:0] CORR_SUB    = 4'd3;

endpackage

// File: rtl/bcd_digit_corr.sv
// Reverse double-dabble digit fix-up: a digit that reached 8+ after a right shift
// had a borrowed ten land in it as 8, so pull it back to 5 by subtracting 3.
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);

  assign d_out = (d_in >= CORR_THRESH) ? (d_in - CORR_SUB) : d_in;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter: one reverse double-dabble step per clock,
// start/busy/done handshake, illegal digits reported through err instead of converted.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t              state, state_nxt;
  logic [4*DIGITS-1:0] bcd_reg, bcd_shift, bcd_corr;
  logic [BIN_W-1:0]    bin_reg, bin_shift;
  logic [CNT_W-1:0]    cnt;
  logic [DIGITS-1:0]   dig_bad;
  logic                any_bad, last_step;

  // The combined {bcd_reg, bin_reg} word moves right; the BCD LSB feeds the binary MSB.
  assign bcd_shift = bcd_reg >> 1;
  assign bin_shift = {bcd_reg[0], bin_reg[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_corr u_corr (
      .d_in  (bcd_shift[4*g +: 4]),
      .d_out (bcd_corr[4*g +: 4])
    );
    assign dig_bad[g] = (bcd_in[4*g +: 4] > BCD_MAX);
  end

  assign any_bad   = |dig_bad;
  assign last_step = (cnt == CNT_W'(BIN_W - 1));
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = any_bad ? S_DONE : S_SHIFT;
      S_SHIFT: if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            bcd_reg <= bcd_in;
            bin_reg <= '0;
            cnt     <= '0;
            if (any_bad) begin
              bin_out <= '0;
              err     <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          bcd_reg <= bcd_corr;
          bin_reg <= bin_shift;
          cnt     <= cnt + CNT_W'(1);
          // Publish the freshly shifted word so the result lands on the DONE-entry edge.
          if (last_step) begin
            bin_out <= bin_shift;
            err     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
